// File: rtl/ice40_spi_tx_feeder_pkg.sv
// Shared widths and types for the SPI transmit feeder and its FIFO.
package ice40_spi_tx_feeder_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned SENT_W = 16;
    // Wide enough for any accept timeout in 1..255.
    localparam int unsigned TMO_W  = 8;

    typedef logic [BYTE_W-1:0] byte_t;

endpackage

// File: rtl/ice40_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers and registered full/empty/level.
module ice40_sync_fifo
    import ice40_spi_tx_feeder_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = BYTE_W,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned PW = AW + 1
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic             o_full,
    output logic             o_empty,
    output logic [PW-1:0]    o_level,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    w_wr_next;
    logic [PW-1:0]    w_rd_next;
    logic [PW-1:0]    w_level_next;
    logic             w_pop_ok;
    logic             w_push_ok;

    // Next pointers; a same-cycle pop frees the slot a push into a full FIFO needs.
    always_comb begin
        w_pop_ok  = i_pop && !o_empty;
        w_push_ok = i_push && (!o_full || w_pop_ok);
        w_wr_next = r_wr_ptr;
        w_rd_next = r_rd_ptr;
        if (i_flush) begin
            w_wr_next = '0;
            w_rd_next = '0;
        end else begin
            if (w_push_ok) w_wr_next = r_wr_ptr + 1'b1;
            if (w_pop_ok)  w_rd_next = r_rd_ptr + 1'b1;
        end
        w_level_next = w_wr_next - w_rd_next;
    end

    // Pointer and status registers, status derived from the next pointers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            o_full   <= 1'b0;
            o_empty  <= 1'b1;
            o_level  <= '0;
        end else begin
            r_wr_ptr <= w_wr_next;
            r_rd_ptr <= w_rd_next;
            o_full   <= (w_level_next == PW'(DEPTH));
            o_empty  <= (w_level_next == '0);
            o_level  <= w_level_next;
        end
    end

    // Storage; a flush discards the write of the same cycle.
    always_ff @(posedge i_clk) begin
        if (w_push_ok && !i_flush) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/ice40_spi_tx_feeder.sv
// Feeds queued bytes to the SPI controller's start/busy handshake, retrying ignored starts.
module ice40_spi_tx_feeder
    import ice40_spi_tx_feeder_pkg::*;
#(
    parameter int unsigned DEPTH          = 16,
    parameter int unsigned ACCEPT_TIMEOUT = 15,
    localparam int unsigned LW = $clog2(DEPTH) + 1
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_push,
    input  byte_t             i_push_data,
    input  logic              i_flush,
    output logic              o_full,
    output logic              o_empty,
    output logic [LW-1:0]     o_level,
    input  logic              i_spi_busy,
    output logic              o_spi_start,
    output byte_t             o_spi_data_out,
    output logic [SENT_W-1:0] o_sent_count,
    output logic              o_overflow,
    output logic              o_timeout_err
);

    typedef enum logic [1:0] {
        StIdle       = 2'd0,
        StIssue      = 2'd1,
        StWaitAccept = 2'd2,
        StWaitDone   = 2'd3
    } state_t;

    state_t           r_state;
    logic [TMO_W-1:0] r_cnt;
    byte_t            w_rd_data;
    logic             w_pop;

    // The head byte leaves the FIFO only once the controller has finished with it.
    assign w_pop = (r_state == StWaitDone) && !i_spi_busy;

    ice40_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (BYTE_W)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_push      (i_push),
        .i_push_data (i_push_data),
        .i_pop       (w_pop),
        .i_flush     (i_flush),
        .o_full      (o_full),
        .o_empty     (o_empty),
        .o_level     (o_level),
        .o_rd_data   (w_rd_data)
    );

    // Sticky overflow: a push dropped because the FIFO was full with nothing leaving.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_overflow <= 1'b0;
        end else if (i_push && o_full && !w_pop) begin
            o_overflow <= 1'b1;
        end
    end

    // Handshake FSM with accept timeout, delivered-byte counter and timeout flag.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state        <= StIdle;
            r_cnt          <= '0;
            o_spi_start    <= 1'b0;
            o_spi_data_out <= '0;
            o_sent_count   <= '0;
            o_timeout_err  <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    // Busy during controller init holds the feeder off.
                    if (!o_empty && !i_spi_busy && !i_flush) begin
                        o_spi_data_out <= w_rd_data;
                        o_spi_start    <= 1'b1;
                        r_state        <= StIssue;
                    end
                end
                StIssue: begin
                    o_spi_start <= 1'b0;
                    r_cnt       <= '0;
                    r_state     <= StWaitAccept;
                end
                StWaitAccept: begin
                    if (i_spi_busy) begin
                        r_state <= StWaitDone;
                    end else if (r_cnt == TMO_W'(ACCEPT_TIMEOUT)) begin
                        // Head byte stays queued and is reissued from idle.
                        o_timeout_err <= 1'b1;
                        r_state       <= StIdle;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StWaitDone: begin
                    // Counts even if a flush in this cycle already emptied the FIFO.
                    if (!i_spi_busy) begin
                        o_sent_count <= o_sent_count + 1'b1;
                        r_state      <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ice40_spi_tx_feeder.sv
// Randomized self-checking bench for ice40_spi_tx_feeder with a queue-based reference model.
module tb_ice40_spi_tx_feeder;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned TMO   = 15;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          i_reset_n = 1'b0;
    logic          i_push = 1'b0;
    logic [7:0]    i_push_data = '0;
    logic          i_flush = 1'b0;
    logic          o_full;
    logic          o_empty;
    logic [LW-1:0] o_level;
    logic          i_spi_busy = 1'b0;
    logic          o_spi_start;
    logic [7:0]    o_spi_data_out;
    logic [15:0]   o_sent_count;
    logic          o_overflow;
    logic          o_timeout_err;

    ice40_spi_tx_feeder #(
        .DEPTH          (DEPTH),
        .ACCEPT_TIMEOUT (TMO)
    ) dut (
        .i_clk          (clk),
        .i_reset_n      (i_reset_n),
        .i_push         (i_push),
        .i_push_data    (i_push_data),
        .i_flush        (i_flush),
        .o_full         (o_full),
        .o_empty        (o_empty),
        .o_level        (o_level),
        .i_spi_busy     (i_spi_busy),
        .o_spi_start    (o_spi_start),
        .o_spi_data_out (o_spi_data_out),
        .o_sent_count   (o_sent_count),
        .o_overflow     (o_overflow),
        .o_timeout_err  (o_timeout_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;

    // Reference model: bytes the feeder owes the controller, head = next/in-flight byte.
    logic [7:0] q[$];
    int  exp_sent      = 0;
    bit  exp_ovf       = 1'b0;
    bit  exp_tmo       = 1'b0;
    bit  inflight_in_q = 1'b0;

    // Controller model knobs and observations.
    bit  hold_busy      = 1'b0;
    bit  rand_busy      = 1'b0;
    int  busy_len       = 10;
    int  ignore_starts  = 0;
    int  ctl_left       = 0;
    bit  prev_start     = 1'b0;
    int  n_starts       = 0;
    int  last_start_cyc = 0;
    int  prev_start_cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SPI controller: busy high for a transaction's length after each accepted start.
    always @(negedge clk) begin
        if (i_reset_n) begin
            if (o_spi_start) begin
                check("start_one_cycle", {31'b0, prev_start}, 32'd0);
                n_starts++;
                prev_start_cyc = last_start_cyc;
                last_start_cyc = cyc;
                if (q.size() > 0) check("data_out", {24'b0, o_spi_data_out}, {24'b0, q[0]});
                else              check("start_with_model_empty", 32'd1, 32'd0);
                if (ignore_starts > 0) begin
                    ignore_starts--;
                end else begin
                    ctl_left      = rand_busy ? int'($urandom_range(2, 8)) : busy_len;
                    inflight_in_q = 1'b1;
                end
            end else if (ctl_left > 0) begin
                ctl_left--;
                if (ctl_left == 0) begin
                    exp_sent++;
                    if (inflight_in_q && q.size() > 0) void'(q.pop_front());
                    inflight_in_q = 1'b0;
                end
            end
            prev_start = o_spi_start;
            i_spi_busy = hold_busy || (ctl_left > 0);
        end
    end

    task automatic push_byte(input logic [7:0] b);
        @(negedge clk);
        i_push      = 1'b1;
        i_push_data = b;
        if (q.size() < DEPTH) q.push_back(b);
        else                  exp_ovf = 1'b1;
        @(negedge clk);
        i_push = 1'b0;
    endtask

    task automatic set_hold(input bit h);
        hold_busy  = h;
        i_spi_busy = h || (ctl_left > 0);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((q.size() != 0 || ctl_left != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) check({tag, "_drain_timeout"}, 32'd0, 32'd1);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_status(input string tag);
        check({tag, "_sent"},  {16'b0, o_sent_count}, 32'(exp_sent & 16'hFFFF));
        check({tag, "_level"}, 32'(o_level), 32'(q.size()));
        check({tag, "_empty"}, {31'b0, o_empty}, {31'b0, q.size() == 0});
        check({tag, "_ovf"},   {31'b0, o_overflow}, {31'b0, exp_ovf});
        check({tag, "_tmo"},   {31'b0, o_timeout_err}, {31'b0, exp_tmo});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_start"}, {31'b0, o_spi_start}, 32'd0);
        check({tag, "_data"},  {24'b0, o_spi_data_out}, 32'd0);
        check({tag, "_full"},  {31'b0, o_full}, 32'd0);
        check_status(tag);
    endtask

    task automatic wait_busy_left(input int target);
        int n;
        n = 0;
        while (ctl_left != target && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) check("wait_busy_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int base_starts;
        int base_sent;
        int pushed;

        // Reset state.
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        i_reset_n = 1'b1;

        // 1: controller busy during init holds off the start.
        set_hold(1'b1);
        push_byte(8'hA5);
        repeat (20) @(negedge clk);
        check("t1_no_start", 32'(n_starts), 32'd0);
        check("t1_level", 32'(o_level), 32'd1);
        set_hold(1'b0);
        drain("t1");
        check("t1_starts", 32'(n_starts), 32'd1);
        check_status("t1");

        // 2: three bytes in order; first start one edge after the push edge.
        base_starts = n_starts;
        @(negedge clk);
        i_push = 1'b1; i_push_data = 8'h01; q.push_back(8'h01);
        @(negedge clk);
        i_push = 1'b0;
        check("t2_lat_k", {31'b0, o_spi_start}, 32'd0);
        @(negedge clk);
        check("t2_lat_k1", {31'b0, o_spi_start}, 32'd1);
        push_byte(8'h02);
        push_byte(8'h03);
        drain("t2");
        check("t2_starts", 32'(n_starts - base_starts), 32'd3);
        check_status("t2");

        // 3: overflow while the controller is busy; the dropped byte is never sent.
        set_hold(1'b1);
        for (int i = 0; i <= DEPTH; i++) push_byte(8'($urandom));
        @(negedge clk);
        check("t3_full", {31'b0, o_full}, 32'd1);
        check("t3_level", 32'(o_level), 32'(DEPTH));
        check("t3_ovf", {31'b0, o_overflow}, 32'd1);
        set_hold(1'b0);
        drain("t3");
        check_status("t3");

        // 4: first start ignored -> timeout, retry of the same byte after TMO+3 cycles.
        base_starts   = n_starts;
        base_sent     = exp_sent;
        ignore_starts = 1;
        push_byte(8'h3C);
        exp_tmo = 1'b1;
        drain("t4");
        check("t4_starts", 32'(n_starts - base_starts), 32'd2);
        check("t4_retry_gap", 32'(last_start_cyc - prev_start_cyc), 32'(TMO + 3));
        check("t4_sent", 32'(exp_sent - base_sent), 32'd1);
        check_status("t4");

        // 5: flush during the first byte's transfer discards the rest.
        base_starts = n_starts;
        base_sent   = exp_sent;
        set_hold(1'b1);
        for (int i = 0; i < 4; i++) push_byte(8'($urandom));
        set_hold(1'b0);
        wait_busy_left(busy_len - 3);
        i_flush = 1'b1;
        q.delete();
        inflight_in_q = 1'b0;
        @(negedge clk);
        i_flush = 1'b0;
        drain("t5");
        repeat (10) @(negedge clk);
        check("t5_starts", 32'(n_starts - base_starts), 32'd1);
        check("t5_sent", 32'(exp_sent - base_sent), 32'd1);
        check_status("t5");

        // Random traffic with random transaction lengths and push gaps.
        rand_busy = 1'b1;
        pushed    = 0;
        while (pushed < 40) begin
            if (q.size() < DEPTH - 1) begin
                push_byte(8'($urandom));
                pushed++;
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain("rand");
        check_status("rand");
        rand_busy = 1'b0;

        // 6: reset asserted mid-transfer, then normal operation resumes.
        push_byte(8'h33);
        wait_busy_left(5);
        i_reset_n     = 1'b0;
        ctl_left      = 0;
        inflight_in_q = 1'b0;
        i_spi_busy    = 1'b0;
        q.delete();
        exp_sent = 0;
        exp_ovf  = 1'b0;
        exp_tmo  = 1'b0;
        #1;
        check_reset_outputs("t6_reset");
        repeat (2) @(negedge clk);
        i_reset_n = 1'b1;
        base_starts = n_starts;
        push_byte(8'h5A);
        drain("t6");
        check("t6_starts", 32'(n_starts - base_starts), 32'd1);
        check_status("t6");

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    // Global guard against a hung run.
    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
